gtp_pll_reset_seq: RTL and testbench
====================================

Name: gtp_pll_reset_seq

Overview:
- Parametrised power-up, reset and lock sequencer for up to NUM_PLLS GTP common PLLs (PLL0/PLL1 per GTPE2_COMMON, several quads).
- Drives each PLL's PD and RESET pins from an independent per-PLL state machine.
- Per-PLL machine features: lock timeout, bounded retries, lock-settle qualification and automatic relock on lock loss.
- Sits between the fabric control logic and the GTPE2_COMMON PLLxPD/PLLxRESET/PLLxLOCK pins.

Parameters:
- NUM_PLLS, 2, number of sequenced PLLs (1..8).
- PLL_EN_MASK, {NUM_PLLS{1'b1}}, bit i=0 holds PLL i powered down; it counts as ready and never fails.
- RESET_CYCLES, 4, cycles PLL reset is held after power-up (>=1).
- LOCK_TIMEOUT, 16, cycles allowed in WAIT_LOCK before a retry (>=2).
- SETTLE_CYCLES, 8, consecutive synchronised-lock cycles required before READY (>=1).
- MAX_RETRIES, 2, timeouts tolerated before FAIL (0..15).

Ports:
- clk  in  1  sequencer clock (free-running, e.g. DRPCLK domain).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled; starts the sequence from IDLE/FAIL.
- shutdown  in  1  forces all PLLs to IDLE; has priority over start.
- pll_lock  in  NUM_PLLS  raw PLLxLOCK, asynchronous to clk.
- pll_pd  out  NUM_PLLS  PLL power-down.
- pll_rst  out  NUM_PLLS  PLL reset.
- pll_ready  out  NUM_PLLS  per-PLL READY state.
- all_ready  out  1  registered AND of pll_ready.
- any_fail  out  1  registered OR of per-PLL FAIL.
- relock_cnt  out  8  saturating count of READY->lock-loss events, all PLLs.

Behaviour:
- Reset values: pll_pd=all 1, pll_rst=all 1, pll_ready=0, all_ready=0, any_fail=0, relock_cnt=0. All states are IDLE and the synchronisers are cleared.
- pll_lock passes through a 2-FF synchroniser per bit (lock_s). All outputs are registered and decoded from state.
- Per-PLL states and outputs (pd, rst, ready):
  - IDLE (1,1,0): start=1 and enabled -> PWRUP, counter=0, retries=0.
  - PWRUP (0,1,0): counter counts RESET_CYCLES cycles, then -> WAIT_LOCK with counter=0. pll_rst therefore deasserts exactly RESET_CYCLES+1 edges after the start-sampling edge.
  - WAIT_LOCK (0,0,0):
    - lock_s=1 -> SETTLE, counter=0.
    - Otherwise, when counter==LOCK_TIMEOUT-1: retries<MAX_RETRIES -> retries+1 and PWRUP; else -> FAIL.
    - If lock_s rises on the timeout cycle, lock wins.
  - SETTLE (0,0,0): lock_s=0 -> WAIT_LOCK with counter=0 (fresh timeout). After SETTLE_CYCLES consecutive lock_s=1 cycles -> READY, retries=0.
  - READY (0,0,1): lock_s=0 -> PWRUP and relock_cnt+1, saturating at 255. Simultaneous losses on k PLLs add k, saturating.
  - FAIL (1,1,0): any_fail contribution=1. start=1 -> PWRUP with retries=0.
- shutdown=1 in any state -> IDLE on the next edge; start is ignored that cycle.
- Disabled PLLs (PLL_EN_MASK bit 0) stay in IDLE permanently with pll_ready forced to 1.
- all_ready is additionally forced to 0 if PLL_EN_MASK==0.
- all_ready and any_fail lag the per-PLL state by 1 cycle.
- Asserting rst_n mid-sequence returns everything to reset values immediately. No start memory is kept.
- Counter width is $clog2(max(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES))+1. Counters never wrap because each state exits at its terminal count.

Decomposition:
- Package gtp_pll_seq_pkg holds:
  - the state enum (IDLE, PWRUP, WAIT_LOCK, SETTLE, READY, FAIL);
  - the counter-width function;
  - the relock_cnt width constant (8).
- Sub-module gtp_pll_seq_chan contains one synchroniser and one FSM, and outputs pd/rst/ready/fail/relock_evt. The top instantiates NUM_PLLS copies via generate and does the aggregation and saturating sum.

Test Plan (defaults, NUM_PLLS=2):
- Normal bring-up:
  - Stimulus: start pulse at edge 0; lock raised on both PLLs 3 cycles after pll_rst falls.
  - Required: pll_pd=0 at edge 1; pll_rst=0 at edge 5; pll_ready at lock+10 edges; all_ready one edge later.
- Timeout/fail:
  - Stimulus: lock never asserts on PLL1.
  - Required: PLL1 goes through exactly 3 PWRUP pulses of pll_rst. Then FAIL, pll_pd[1]=1, any_fail=1; PLL0 reaches READY independently. A new start recovers PLL1.
- Settle glitch:
  - Stimulus: lock high for 5 cycles, low for 1, then high.
  - Required: no ready after the first 5 cycles; ready after 8 clean cycles; no timeout counted.
- Relock:
  - Stimulus: drop lock on both PLLs simultaneously while READY.
  - Required: relock_cnt 0->2; pll_rst pulses for 4 cycles; ready returns.
  - Also: force 300 relocks; relock_cnt holds at 255.
- Mask/shutdown:
  - Stimulus: PLL_EN_MASK=2'b01.
  - Required: pll_pd[1] stays 1; all_ready follows PLL0 only.
  - Also: shutdown and start asserted together -> all IDLE with pd=1.
- Async reset:
  - Stimulus: rst_n low mid-WAIT_LOCK, with no clock edge.
  - Required: outputs return to reset values immediately.

Source files
------------

// File: rtl/gtp_pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gtp_pll_seq_pkg
// Purpose  : Shared types and helpers for the GTP common-PLL reset sequencer.
//            Holds the per-PLL state encoding, the counter-width helper and
//            the width of the aggregate relock counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gtp_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_READY     = 3'd4,
    ST_FAIL      = 3'd5
  } pll_state_e;

  localparam int RELOCK_CNT_W = 8;

  // One shared counter serves every timed state, so it is sized for the
  // largest terminal count plus a guard bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gtp_pll_seq_chan.sv
`default_nettype none
// ============================================================================
// Module   : gtp_pll_seq_chan
// Purpose  : Single-PLL power-up / reset / lock sequencer. Synchronises the
//            raw PLLxLOCK and runs the IDLE->PWRUP->WAIT_LOCK->SETTLE->READY
//            flow with timeout, bounded retry and relock on lock loss.
// Ports    : clk, rst_n          - clock, async active-low reset
//            start_i, shutdown_i - sequence control (shutdown has priority)
//            pll_lock_i          - raw lock, asynchronous to clk
//            pd_o, rst_o         - registered PLL power-down / reset
//            ready_o, fail_o     - registered READY / FAIL state flags
//            relock_evt_o        - one-cycle strobe on READY lock loss
// Revision : 1.0 - initial release
// ============================================================================
module gtp_pll_seq_chan
  import gtp_pll_seq_pkg::*;
#(
  parameter bit ENABLE        = 1'b1,
  parameter int RESET_CYCLES  = 4,
  parameter int LOCK_TIMEOUT  = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_RETRIES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic shutdown_i,
  input  logic pll_lock_i,
  output logic pd_o,
  output logic rst_o,
  output logic ready_o,
  output logic fail_o,
  output logic relock_evt_o
);

  localparam int CNT_W = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that sees lock_s=1 is the first qualified cycle, so
  // SETTLE itself only has to see SETTLE_CYCLES-1 more.
  localparam logic [CNT_W-1:0] STL_LAST =
    CNT_W'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic             pd_q, rst_q, ready_q, fail_q;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], pll_lock_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    relock_evt_o = 1'b0;
    if (shutdown_i || !ENABLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAIL: begin
          if (start_i) begin
            state_d = ST_PWRUP;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        ST_PWRUP: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is tested first so it wins on the timeout cycle.
          if (lock_s) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_PWRUP;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= STL_LAST) begin
            state_d = ST_READY;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (!lock_s) begin
            state_d      = ST_PWRUP;
            cnt_d        = '0;
            relock_evt_o = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pin outputs are a registered decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_q    <= 1'b1;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      pd_q    <= (state_q == ST_IDLE) || (state_q == ST_FAIL);
      rst_q   <= (state_q == ST_IDLE) || (state_q == ST_FAIL) ||
                 (state_q == ST_PWRUP);
      ready_q <= (state_q == ST_READY) || !ENABLE;
      fail_q  <= (state_q == ST_FAIL);
    end
  end

  assign pd_o    = pd_q;
  assign rst_o   = rst_q;
  assign ready_o = ready_q;
  assign fail_o  = fail_q;

endmodule
`default_nettype wire

// File: rtl/gtp_pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : gtp_pll_reset_seq
// Purpose  : Power-up / reset / lock sequencer for NUM_PLLS GTPE2_COMMON
//            PLLs. One independent channel per PLL plus aggregate status.
// Ports    : clk, rst_n      - clock, async active-low reset
//            start_i         - level-sampled sequence start
//            shutdown_i      - force all PLLs to IDLE (priority over start)
//            pll_lock_i      - raw PLLxLOCK per PLL
//            pll_pd_o        - PLLxPD per PLL
//            pll_rst_o       - PLLxRESET per PLL
//            pll_ready_o     - per-PLL READY
//            all_ready_o     - registered AND of pll_ready_o
//            any_fail_o      - registered OR of per-PLL FAIL
//            relock_cnt_o    - saturating count of READY lock-loss events
// Revision : 1.0 - initial release
// ============================================================================
module gtp_pll_reset_seq
  import gtp_pll_seq_pkg::*;
#(
  parameter int                  NUM_PLLS      = 2,
  parameter logic [NUM_PLLS-1:0] PLL_EN_MASK   = {NUM_PLLS{1'b1}},
  parameter int                  RESET_CYCLES  = 4,
  parameter int                  LOCK_TIMEOUT  = 16,
  parameter int                  SETTLE_CYCLES = 8,
  parameter int                  MAX_RETRIES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    shutdown_i,
  input  logic [NUM_PLLS-1:0]     pll_lock_i,
  output logic [NUM_PLLS-1:0]     pll_pd_o,
  output logic [NUM_PLLS-1:0]     pll_rst_o,
  output logic [NUM_PLLS-1:0]     pll_ready_o,
  output logic                    all_ready_o,
  output logic                    any_fail_o,
  output logic [RELOCK_CNT_W-1:0] relock_cnt_o
);

  localparam int EVT_W = $clog2(NUM_PLLS + 1);
  localparam int SUM_W = RELOCK_CNT_W + 1;

  logic [NUM_PLLS-1:0]     chan_fail;
  logic [NUM_PLLS-1:0]     chan_evt;
  logic [EVT_W-1:0]        evt_sum;
  logic [SUM_W-1:0]        relock_sum;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
  logic                    all_ready_q, any_fail_q;

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
    gtp_pll_seq_chan #(
      .ENABLE       (PLL_EN_MASK[i]),
      .RESET_CYCLES (RESET_CYCLES),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MAX_RETRIES  (MAX_RETRIES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .shutdown_i  (shutdown_i),
      .pll_lock_i  (pll_lock_i[i]),
      .pd_o        (pll_pd_o[i]),
      .rst_o       (pll_rst_o[i]),
      .ready_o     (pll_ready_o[i]),
      .fail_o      (chan_fail[i]),
      .relock_evt_o(chan_evt[i])
    );
  end

  // Several PLLs can lose lock on the same cycle; each one is counted.
  always_comb begin
    evt_sum = '0;
    for (int i = 0; i < NUM_PLLS; i++) begin
      evt_sum = evt_sum + EVT_W'(chan_evt[i]);
    end
    relock_sum = {1'b0, relock_q} + SUM_W'(evt_sum);
    // evt_sum never exceeds 8, so the guard bit alone flags overflow.
    relock_d   = relock_sum[SUM_W-1] ? {RELOCK_CNT_W{1'b1}}
                                     : relock_sum[RELOCK_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_q    <= '0;
      all_ready_q <= 1'b0;
      any_fail_q  <= 1'b0;
    end else begin
      relock_q    <= relock_d;
      all_ready_q <= (PLL_EN_MASK != '0) && (&pll_ready_o);
      any_fail_q  <= |chan_fail;
    end
  end

  assign relock_cnt_o = relock_q;
  assign all_ready_o  = all_ready_q;
  assign any_fail_o   = any_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_gtp_pll_reset_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gtp_pll_reset_seq
// Purpose  : Scoreboard bench for gtp_pll_reset_seq (default DUT plus a
//            second instance with PLL1 masked off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gtp_pll_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_i;
  logic       shutdown_i;
  logic [1:0] lock;

  logic [1:0] pll_pd, pll_rst, pll_ready;
  logic       all_ready, any_fail;
  logic [7:0] relock_cnt;

  logic [1:0] m_pd, m_rst, m_ready;
  logic       m_all_ready, m_any_fail;
  logic [7:0] m_relock_cnt;

  gtp_pll_reset_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .shutdown_i(shutdown_i),
    .pll_lock_i(lock), .pll_pd_o(pll_pd), .pll_rst_o(pll_rst),
    .pll_ready_o(pll_ready), .all_ready_o(all_ready), .any_fail_o(any_fail),
    .relock_cnt_o(relock_cnt)
  );

  gtp_pll_reset_seq #(.PLL_EN_MASK(2'b01)) u_mask (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .shutdown_i(shutdown_i),
    .pll_lock_i(lock), .pll_pd_o(m_pd), .pll_rst_o(m_rst),
    .pll_ready_o(m_ready), .all_ready_o(m_all_ready), .any_fail_o(m_any_fail),
    .relock_cnt_o(m_relock_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return 32'(pll_pd);
      1: return 32'(pll_rst);
      2: return 32'(pll_ready);
      3: return 32'(all_ready);
      4: return 32'(any_fail);
      5: return 32'(relock_cnt);
      6: return 32'(m_pd);
      7: return 32'(m_ready);
      8: return 32'(m_all_ready);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input logic [31:0] e,
                           input string name);
    exp_t x;
    x.cyc  = c;
    x.sel  = sel;
    x.exp  = e;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic check_now(input string name, input logic [31:0] act,
                           input logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, e);
    end
  endtask

  // Monitor: compares each queued expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = observe(e.sel);
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)",
                 e.name, e.cyc, cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s @cyc %0d: got %0h expected %0h",
                 e.name, cyc, act, e.exp);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never reached", q.size());
      q.delete();
    end
  endtask

  // Start is sampled on the next rising edge; that edge number is returned.
  task automatic do_start(output int s);
    start_i = 1'b1;
    @(negedge clk);
    s = cyc;
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int s, s2, c, x0;
  int exp_cnt;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; shutdown_i = 1'b0; lock = 2'b00;
    @(negedge clk);
    // Reset values
    expect_at(cyc + 1, 0, 3, "rst_pd");
    expect_at(cyc + 1, 1, 3, "rst_rst");
    expect_at(cyc + 1, 2, 0, "rst_ready");
    expect_at(cyc + 1, 3, 0, "rst_all_ready");
    expect_at(cyc + 1, 4, 0, "rst_any_fail");
    expect_at(cyc + 1, 5, 0, "rst_relock");
    expect_at(cyc + 1, 7, 0, "rst_mask_ready");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal bring-up; lock sampled first at start-edge + 8
    do_start(s);
    expect_at(s + 1,  0, 0, "up_pd_low");
    expect_at(s + 1,  1, 3, "up_rst_held");
    expect_at(s + 1,  6, 2, "mask_pd1_high");
    expect_at(s + 4,  1, 3, "up_rst_still_held");
    expect_at(s + 5,  1, 0, "up_rst_low");
    expect_at(s + 17, 2, 0, "up_ready_early");
    expect_at(s + 18, 2, 3, "up_ready");
    expect_at(s + 18, 3, 0, "up_all_ready_lag");
    expect_at(s + 18, 7, 3, "mask_ready");
    expect_at(s + 19, 3, 1, "up_all_ready");
    expect_at(s + 19, 8, 1, "mask_all_ready");
    expect_at(s + 19, 6, 2, "mask_pd1_still_high");
    wait_cyc(s + 7);
    lock = 2'b11;
    wait_cyc(s + 20);

    // Simultaneous lock loss on both PLLs
    c = cyc;
    lock = 2'b00;
    expect_at(c + 2,  5, 0, "relock_before");
    expect_at(c + 3,  5, 2, "relock_two");
    expect_at(c + 4,  1, 3, "relock_rst_on");
    expect_at(c + 4,  2, 0, "relock_ready_off");
    expect_at(c + 7,  1, 3, "relock_rst_4th");
    expect_at(c + 8,  1, 0, "relock_rst_off");
    expect_at(c + 16, 2, 3, "relock_ready_back");
    expect_at(c + 17, 3, 1, "relock_all_ready_back");
    wait_cyc(c + 3);
    lock = 2'b11;
    wait_cyc(c + 17);

    // Repeated relocks up to saturation (300 events total)
    exp_cnt = 2;
    for (int k = 0; k < 149; k++) begin
      c = cyc;
      lock = 2'b00;
      exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
      expect_at(c + 3,  5, exp_cnt, "relock_sat");
      expect_at(c + 16, 2, 3, "relock_loop_ready");
      wait_cyc(c + 3);
      lock = 2'b11;
      wait_cyc(c + 17);
    end
    expect_at(cyc + 1, 5, 255, "relock_final_255");
    drain();

    // Shutdown and start together
    x0 = cyc;
    shutdown_i = 1'b1;
    start_i    = 1'b1;
    expect_at(x0 + 2, 0, 3, "sd_pd");
    expect_at(x0 + 2, 1, 3, "sd_rst");
    expect_at(x0 + 2, 2, 0, "sd_ready");
    expect_at(x0 + 2, 6, 3, "sd_mask_pd");
    expect_at(x0 + 3, 3, 0, "sd_all_ready");
    expect_at(x0 + 3, 5, 255, "sd_relock_hold");
    expect_at(x0 + 4, 0, 3, "sd_pd_hold");
    wait_cyc(x0 + 4);
    shutdown_i = 1'b0;
    start_i    = 1'b0;
    expect_at(x0 + 7, 0, 3, "sd_idle_after");
    drain();

    // Asynchronous reset in the middle of WAIT_LOCK
    lock = 2'b00;
    do_start(s);
    expect_at(s + 6, 1, 0, "ar_in_wait_rst");
    expect_at(s + 6, 0, 0, "ar_in_wait_pd");
    wait_cyc(s + 7);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("ar_pd",        32'(pll_pd), 3);
    check_now("ar_rst",       32'(pll_rst), 3);
    check_now("ar_ready",     32'(pll_ready), 0);
    check_now("ar_all_ready", 32'(all_ready), 0);
    check_now("ar_any_fail",  32'(any_fail), 0);
    check_now("ar_relock",    32'(relock_cnt), 0);
    @(negedge clk);
    do_reset();

    // Timeout / retry / fail on PLL1, PLL0 locks normally
    lock = 2'b01;
    do_start(s);
    expect_at(s + 13, 2, 1, "to_pll0_ready");
    expect_at(s + 20, 1, 0, "to_rst_1st_end");
    expect_at(s + 21, 1, 2, "to_rst_2nd");
    expect_at(s + 25, 1, 0, "to_rst_2nd_end");
    expect_at(s + 40, 1, 0, "to_rst_3rd_wait");
    expect_at(s + 41, 1, 2, "to_rst_3rd");
    expect_at(s + 45, 1, 0, "to_rst_3rd_end");
    expect_at(s + 60, 0, 0, "to_pd_before_fail");
    expect_at(s + 61, 0, 2, "to_fail_pd");
    expect_at(s + 61, 1, 2, "to_fail_rst");
    expect_at(s + 61, 4, 0, "to_any_fail_lag");
    expect_at(s + 62, 4, 1, "to_any_fail");
    expect_at(s + 62, 3, 0, "to_all_ready_low");
    expect_at(s + 70, 1, 2, "to_no_4th_retry");
    wait_cyc(s + 70);
    lock = 2'b11;
    do_start(s2);
    expect_at(s2 + 1,  0, 0, "rec_pd");
    expect_at(s2 + 2,  4, 0, "rec_any_fail_clear");
    expect_at(s2 + 12, 2, 1, "rec_pll1_settling");
    expect_at(s2 + 13, 2, 3, "rec_ready");
    expect_at(s2 + 14, 3, 1, "rec_all_ready");
    drain();
    do_reset();

    // Settle glitch: 5 lock cycles, 1 low, then clean
    lock = 2'b00;
    do_start(s);
    expect_at(s + 20, 2, 0, "gl_no_early_ready");
    expect_at(s + 23, 2, 0, "gl_ready_pending");
    expect_at(s + 24, 2, 3, "gl_ready");
    expect_at(s + 24, 1, 0, "gl_no_retry");
    expect_at(s + 25, 4, 0, "gl_no_fail");
    expect_at(s + 25, 3, 1, "gl_all_ready");
    wait_cyc(s + 7);
    lock = 2'b11;
    wait_cyc(s + 12);
    lock = 2'b00;
    wait_cyc(s + 13);
    lock = 2'b11;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
